// File: rtl/cic_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : cic_ctrl                                                      |
// | Brief  : Sequencer for an order-2 CIC decimator: clear/enable control, |
// |          decimation strobe, settling discard and valid/ready output.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module cic_ctrl #(
  parameter int REGISTER_WIDTH = 20,
  parameter int RATIO_WIDTH    = 10,
  parameter int SETTLE_SAMPLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [RATIO_WIDTH-1:0]    cfg_ratio_i,
  input  logic                      cfg_enable_i,
  input  logic                      cfg_flush_i,
  output logic                      cic_clear_o,
  output logic                      cic_int_en_o,
  output logic                      cic_dec_stb_o,
  input  logic [REGISTER_WIDTH-1:0] cic_data_i,
  output logic [REGISTER_WIDTH-1:0] out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      overrun_o,
  output logic [1:0]                state_o
);

  localparam int                     c_DW           = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [c_DW-1:0]        c_LAST_DISCARD = c_DW'(SETTLE_SAMPLES - 1);
  localparam logic [c_DW-1:0]        c_DISCARD_ONE  = c_DW'(1);
  localparam logic [RATIO_WIDTH-1:0] c_RATIO_ONE    = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH-1:0] c_RATIO_MIN    = RATIO_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t                    r_state;
  logic [RATIO_WIDTH-1:0]    r_ratio;
  logic [RATIO_WIDTH-1:0]    r_phase;
  logic [c_DW-1:0]           r_discard;
  logic                      r_cap;
  logic [REGISTER_WIDTH-1:0] r_data;
  logic                      r_valid;
  logic                      r_overrun;

  logic w_active;
  logic w_wrap;

  assign w_active = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_wrap   = (r_phase == (r_ratio - c_RATIO_ONE));

  // Filter-facing controls are pure decodes of the state and phase registers.
  assign cic_clear_o   = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign cic_int_en_o  = w_active;
  assign cic_dec_stb_o = w_active && w_wrap;
  assign out_data_o    = r_data;
  assign out_valid_o   = r_valid;
  assign overrun_o     = r_overrun;
  assign state_o       = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ratio   <= c_RATIO_MIN;
      r_phase   <= '0;
      r_discard <= '0;
      r_cap     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cap <= 1'b0;
      if (r_valid && out_ready_i) begin
        r_valid <= 1'b0;
      end

      // Disable and flush both abandon any strobe/capture in flight.
      if (!cfg_enable_i) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
      end else if (cfg_flush_i && w_active) begin
        r_state <= S_CLEAR;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CLEAR;
          end
          S_CLEAR: begin
            r_ratio   <= (cfg_ratio_i < c_RATIO_MIN) ? c_RATIO_MIN : cfg_ratio_i;
            r_phase   <= '0;
            r_discard <= '0;
            r_overrun <= 1'b0;
            r_state   <= S_SETTLE;
          end
          S_SETTLE, S_RUN: begin
            r_phase <= w_wrap ? '0 : (r_phase + c_RATIO_ONE);
            r_cap   <= w_wrap;
            if (r_cap) begin
              if (r_state == S_SETTLE) begin
                r_discard <= r_discard + c_DISCARD_ONE;
                if (r_discard == c_LAST_DISCARD) begin
                  r_state <= S_RUN;
                end
              end else begin
                r_data  <= cic_data_i;
                r_valid <= 1'b1;
                if (r_valid && !out_ready_i) begin
                  r_overrun <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_ctrl.sv
`default_nettype none
// tb_cic_ctrl: directed stimulus for cic_ctrl with a decoupled output-data scoreboard.
module tb_cic_ctrl;

  localparam int            RW = 20;
  localparam logic [RW-1:0] D  = 20'h50000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic          ready;
  logic [9:0]    ratio;
  logic          clr;
  logic          inten;
  logic          stb;
  logic          valid;
  logic          ovr;
  logic [RW-1:0] cdata;
  logic [RW-1:0] odata;
  logic [1:0]    st;

  int            cyc        = 0;
  int            t0         = 0;
  int            compared   = 0;
  int            mismatched = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;

  cic_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_ratio_i  (ratio),
    .cfg_enable_i (en),
    .cfg_flush_i  (flush),
    .cic_clear_o  (clr),
    .cic_int_en_o (inten),
    .cic_dec_stb_o(stb),
    .cic_data_i   (cdata),
    .out_data_o   (odata),
    .out_valid_o  (valid),
    .out_ready_i  (ready),
    .overrun_o    (ovr),
    .state_o      (st)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comb data tags each cycle with its number relative to the enabling edge.
  assign cdata = D + RW'(cyc - t0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc - t0);
    end
  endtask

  task automatic goto(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic start(input logic [9:0] r, input logic rdy);
    ratio = r;
    ready = rdy;
    en    = 1'b1;
    t0    = cyc;
  endtask

  task automatic stop();
    en    = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_state", st, 0);
    chk("idle_clear", clr, 1);
    chk("idle_inten", inten, 0);
    chk("idle_stb", stb, 0);
    chk("idle_valid", valid, 0);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (valid && ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected: got %0h expected none", odata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (odata !== mon_exp) begin
            mismatched++;
            $display("FAIL sb_data: got %0h expected %0h", odata, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; ready = 1'b0; ratio = 10'd4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_clear", clr, 1);
    chk("rst_inten", inten, 0);
    chk("rst_stb", stb, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_data", odata, 0);

    // R=4, consumer always ready
    start(10'd4, 1'b1);
    exp_q.push_back(D + 20'd14);
    exp_q.push_back(D + 20'd18);
    exp_q.push_back(D + 20'd22);
    goto(1);
    chk("t1_state_clear", st, 1);
    chk("t1_clear", clr, 1);
    for (int k = 2; k <= 16; k++) begin
      goto(k);
      chk("t1_stb", stb, (k == 5 || k == 9 || k == 13));
      if (k == 2) begin
        chk("t1_state_settle", st, 2);
        chk("t1_clear_low", clr, 0);
        chk("t1_inten", inten, 1);
      end
      if (k == 10) chk("t1_still_settle", st, 2);
      if (k == 11) chk("t1_run", st, 3);
      if (k == 14) chk("t1_no_valid_yet", valid, 0);
      if (k == 15) begin
        chk("t1_first_valid", valid, 1);
        chk("t1_first_data", odata, D + 20'd14);
      end
    end
    goto(24);
    stop();

    // Ratio clamp: 0 and 1 both behave as 2
    start(10'd0, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      goto(k);
      chk("t2_clamp0_stb", stb, (k % 2 == 1));
    end
    stop();
    start(10'd1, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      goto(k);
      chk("t2_clamp1_stb", stb, (k % 2 == 1));
    end
    stop();

    // R=4 stalled consumer: back-to-back, overrun, then flush to R=8
    start(10'd4, 1'b0);
    goto(15);
    chk("t3_valid15", valid, 1);
    chk("t3_data15", odata, D + 20'd14);
    chk("t3_ovr15", ovr, 0);
    exp_q.push_back(D + 20'd14);
    exp_q.push_back(D + 20'd18);
    goto(18);
    ready = 1'b1;
    goto(19);
    chk("t3_b2b_valid", valid, 1);
    chk("t3_b2b_data", odata, D + 20'd18);
    chk("t3_b2b_ovr", ovr, 0);
    goto(20);
    ready = 1'b0;
    goto(23);
    chk("t3_valid23", valid, 1);
    chk("t3_data23", odata, D + 20'd22);
    chk("t3_ovr23", ovr, 0);
    goto(27);
    chk("t3_ovr_valid", valid, 1);
    chk("t3_ovr_data", odata, D + 20'd26);
    chk("t3_ovr_set", ovr, 1);
    goto(28);
    chk("t3_ovr_sticky", ovr, 1);
    ratio = 10'd8;
    flush = 1'b1;
    goto(29);
    flush = 1'b0;
    chk("t3_flush_state", st, 1);
    chk("t3_flush_clear", clr, 1);
    chk("t3_flush_valid", valid, 0);
    chk("t3_flush_ovr_kept", ovr, 1);
    goto(30);
    chk("t3_settle_state", st, 2);
    chk("t3_settle_clear", clr, 0);
    chk("t3_ovr_cleared", ovr, 0);
    goto(36); chk("t3_stb36", stb, 0);
    goto(37); chk("t3_stb37", stb, 1);
    goto(44); chk("t3_stb44", stb, 0);
    goto(45); chk("t3_stb45", stb, 1);
    goto(46); chk("t3_state46", st, 2);
    goto(47); chk("t3_state47", st, 3);
    goto(50);
    exp_q.push_back(D + 20'd54);
    ready = 1'b1;
    goto(54); chk("t3_valid54", valid, 0);
    goto(55);
    chk("t3_valid55", valid, 1);
    chk("t3_data55", odata, D + 20'd54);
    goto(56);
    stop();

    // Overrun survives a disable
    start(10'd0, 1'b0);
    goto(9);
    chk("t4_valid9", valid, 1);
    chk("t4_data9", odata, D + 20'd8);
    chk("t4_ovr9", ovr, 0);
    goto(11);
    chk("t4_data11", odata, D + 20'd10);
    chk("t4_ovr11", ovr, 1);
    en = 1'b0;
    goto(12);
    chk("t4_dis_state", st, 0);
    chk("t4_dis_valid", valid, 0);
    chk("t4_dis_ovr_kept", ovr, 1);
    chk("t4_dis_clear", clr, 1);
    stop();
    chk("t4_ovr_after_idle", ovr, 1);

    // Disable mid-SETTLE
    start(10'd4, 1'b1);
    goto(2);
    chk("t5_state2", st, 2);
    chk("t5_ovr_cleared", ovr, 0);
    goto(7);
    en = 1'b0;
    goto(8);
    chk("t5_dis_state", st, 0);
    chk("t5_dis_clear", clr, 1);
    chk("t5_dis_inten", inten, 0);
    chk("t5_dis_stb", stb, 0);
    stop();

    // Reset mid-RUN with a sample held and overrun set
    start(10'd0, 1'b0);
    goto(11);
    chk("t6_valid11", valid, 1);
    chk("t6_ovr11", ovr, 1);
    rst = 1'b1;
    goto(12);
    chk("t6_rst_state", st, 0);
    chk("t6_rst_clear", clr, 1);
    chk("t6_rst_inten", inten, 0);
    chk("t6_rst_stb", stb, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_ovr", ovr, 0);
    chk("t6_rst_data", odata, 0);
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
